// File: rtl/bin_dec_seq_if.sv
// Handshake and data bundle for the binary-to-BCD converter.
// Requester drives START/BIN_IN; converter returns status and result.
interface bin_dec_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                  START;
  logic [WIDTH-1:0]      BIN_IN;
  logic                  BUSY;
  logic                  DONE;
  logic [4*DIGITS-1:0]   BCD_OUT;
  logic                  OVERFLOW;

  modport master (
    output START, BIN_IN,
    input  BUSY, DONE, BCD_OUT, OVERFLOW
  );

  modport slave (
    input  START, BIN_IN,
    output BUSY, DONE, BCD_OUT, OVERFLOW
  );
endinterface

// File: rtl/bin_dec_seq.sv
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// START/BUSY/DONE handshake; sticky flag for values beyond DIGITS digits.
module bin_dec_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic         CLK,
  input  logic         RESET_N,
  bin_dec_seq_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic { IDLE, SHIFT } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    acc_q, acc_d, adj;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q, ovf_d;
  logic             busy_q, done_q;
  logic [BW-1:0]    res_q;
  logic             res_ovf_q;

  // Digits carry nothing between them; the bit leaving the top is the overflow.
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {acc_d, sh_d} = {adj, sh_q} << 1;
    ovf_d = ovf_q | adj[BW-1];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      res_q     <= '0;
      res_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.START) begin
            sh_q    <= bus.BIN_IN;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= CW'(WIDTH);
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sh_q  <= sh_d;
          acc_q <= acc_d;
          ovf_q <= ovf_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            res_q     <= acc_d;
            res_ovf_q <= ovf_d;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.BCD_OUT  = res_q;
  assign bus.OVERFLOW = res_ovf_q;
endmodule

// File: tb/tb_bin_dec_seq.sv
// Directed and swept checks of bin_dec_seq across several
// WIDTH/DIGITS combinations, all sharing one clock and reset.
module tb_bin_dec_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  bit   sweep_go = 1'b0;
  bit   sw_done [4];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned p10(input int d);
    longint unsigned r = 1;
    for (int i = 0; i < d; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [63:0] ref_bcd(input longint unsigned v,
                                          input int d);
    logic [63:0] r = '0;
    longint unsigned t = v;
    for (int i = 0; i < d; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit all_sw();
    bit a = 1'b1;
    for (int i = 0; i < 4; i++) a = a & sw_done[i];
    return a;
  endfunction

  bin_dec_seq_if #(.WIDTH(16), .DIGITS(5)) i5 ();
  bin_dec_seq_if #(.WIDTH(16), .DIGITS(4)) i4 ();

  bin_dec_seq #(.WIDTH(16), .DIGITS(5)) u5 (
    .CLK(clk), .RESET_N(rst_n), .bus(i5.slave));
  bin_dec_seq #(.WIDTH(16), .DIGITS(4)) u4 (
    .CLK(clk), .RESET_N(rst_n), .bus(i4.slave));

  localparam logic [31:0] SWP = {8'd32, 8'd16, 8'd8, 8'd1};
  localparam logic [31:0] SDP = {8'd10, 8'd5, 8'd3, 8'd1};

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int W = int'(SWP[8*g +: 8]);
    localparam int D = int'(SDP[8*g +: 8]);
    bin_dec_seq_if #(.WIDTH(W), .DIGITS(D)) sif ();
    bin_dec_seq #(.WIDTH(W), .DIGITS(D)) u (
      .CLK(clk), .RESET_N(rst_n), .bus(sif.slave));

    initial begin
      longint unsigned v, mask;
      int k;
      string tg;
      sif.START  = 1'b0;
      sif.BIN_IN = '0;
      mask = (W == 64) ? '1 : ((64'd1 << W) - 1);
      wait (sweep_go);
      for (int n = 0; n < 8; n++) begin
        v = longint'($urandom);
        if (n == 0) v = mask;
        if (n == 1) v = 0;
        if (n == 2) v = p10(D) - 1;
        if (n == 3) v = p10(D);
        v = v & mask;
        tg = $sformatf("sw_w%0d_d%0d_n%0d", W, D, n);
        @(negedge clk);
        sif.START  = 1'b1;
        sif.BIN_IN = W'(v);
        @(negedge clk);
        sif.START = 1'b0;
        k = 0;
        while (!sif.DONE && k < W + 4) begin
          @(negedge clk);
          k++;
        end
        chk({tg, "_done"}, 64'(sif.DONE), 64'd1);
        chk({tg, "_bcd"}, 64'(sif.BCD_OUT), ref_bcd(v, D));
        chk({tg, "_ovf"}, 64'(sif.OVERFLOW), 64'(v > p10(D) - 1));
      end
      sw_done[g] = 1'b1;
    end
  end

  task automatic conv(input string tag, input logic [15:0] v,
                      input logic [19:0] e5, input logic [15:0] e4,
                      input logic o4);
    int n;
    @(negedge clk);
    i5.START = 1'b1; i5.BIN_IN = v;
    i4.START = 1'b1; i4.BIN_IN = v;
    @(negedge clk);
    i5.START = 1'b0; i4.START = 1'b0;
    i5.BIN_IN = ~v;  i4.BIN_IN = ~v;
    n = 0;
    while (i5.BUSY && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd16);
    chk({tag, "_done"}, 64'(i5.DONE), 64'd1);
    chk({tag, "_bcd5"}, 64'(i5.BCD_OUT), 64'(e5));
    chk({tag, "_ovf5"}, 64'(i5.OVERFLOW), 64'd0);
    chk({tag, "_done4"}, 64'(i4.DONE), 64'd1);
    chk({tag, "_bcd4"}, 64'(i4.BCD_OUT), 64'(e4));
    chk({tag, "_ovf4"}, 64'(i4.OVERFLOW), 64'(o4));
    @(negedge clk);
    chk({tag, "_pulse"}, 64'(i5.DONE), 64'd0);
  endtask

  initial begin
    int  n;
    bit  seen;
    i5.START = 1'b0; i5.BIN_IN = '0;
    i4.START = 1'b0; i4.BIN_IN = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(i5.BUSY), 64'd0);
    chk("rst_done", 64'(i5.DONE), 64'd0);
    chk("rst_bcd", 64'(i5.BCD_OUT), 64'd0);
    chk("rst_ovf", 64'(i5.OVERFLOW), 64'd0);
    rst_n = 1'b1;

    conv("v12345", 16'd12345, 20'h12345, 16'h2345, 1'b1);
    conv("v0",     16'd0,     20'h00000, 16'h0000, 1'b0);
    conv("v9999",  16'd9999,  20'h09999, 16'h9999, 1'b0);
    conv("v10000", 16'd10000, 20'h10000, 16'h0000, 1'b1);
    conv("v59999", 16'd59999, 20'h59999, 16'h9999, 1'b1);
    conv("v60000", 16'd60000, 20'h60000, 16'h0000, 1'b1);
    conv("v65535", 16'd65535, 20'h65535, 16'h5535, 1'b1);

    // START held high: back-to-back conversions every 17 cycles
    @(negedge clk);
    i5.START = 1'b1; i5.BIN_IN = 16'd1;
    @(negedge clk);
    i5.BIN_IN = 16'd2;
    n = 0;
    while (!i5.DONE && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tp_done1", 64'(i5.DONE), 64'd1);
    chk("tp_bcd1", 64'(i5.BCD_OUT), 64'h00001);
    @(negedge clk);
    i5.BIN_IN = 16'd7;
    chk("tp_nodbl", 64'(i5.DONE), 64'd0);
    n = 1;
    while (!i5.DONE && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) i5.START = 1'b0;
      if (n == 8) i5.START = 1'b1;
      if (n == 9) i5.START = 1'b0;
    end
    chk("tp_gap", 64'(n), 64'd17);
    chk("tp_bcd2", 64'(i5.BCD_OUT), 64'h00002);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | i5.DONE;
    end
    chk("tp_noextra", 64'(seen), 64'd0);

    // Asynchronous abort mid-conversion
    @(negedge clk);
    i5.START = 1'b1; i5.BIN_IN = 16'd65535;
    @(negedge clk);
    i5.START = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ab_busy", 64'(i5.BUSY), 64'd0);
    chk("ab_done", 64'(i5.DONE), 64'd0);
    chk("ab_bcd", 64'(i5.BCD_OUT), 64'd0);
    chk("ab_ovf", 64'(i5.OVERFLOW), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | i5.DONE | i5.BUSY;
    end
    chk("ab_nodone", 64'(seen), 64'd0);
    conv("v42", 16'd42, 20'h00042, 16'h0042, 1'b0);

    sweep_go = 1'b1;
    n = 0;
    while (!all_sw() && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("sweep_end", 64'(all_sw()), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bin_dec_seq.md
# bin_dec_seq

Sequential, parametrised binary-to-BCD converter for the CPU display and decimal-output path. It converts an unsigned WIDTH-bit value into DIGITS packed BCD digits with a shift-and-add-3 (double-dabble) datapath, one input bit per clock. A START/BUSY/DONE handshake controls each conversion, and the block flags values that do not fit in DIGITS digits. It replaces a chain of per-digit combinational compare/subtract stages with one small iterative engine.

## Interface
Parameters:
- WIDTH, 16: binary input width; legal range is 1 to 32.
- DIGITS, 5: number of BCD output digits; legal range is 1 to 10.

Ports:
- CLK  input  1  single clock; all state changes on the rising edge.
- RESET_N  input  1  reset, asynchronous and active-low.
- START  input  1  conversion request; sampled only in IDLE.
- BIN_IN  input  WIDTH  unsigned value; captured on the accepting edge.
- BUSY  output  1  high while a conversion is in progress.
- DONE  output  1  one-cycle pulse when BCD_OUT/OVERFLOW are updated.
- BCD_OUT  output  4*DIGITS  result; digit i in [4i+3:4i], digit 0 = units.
- OVERFLOW  output  1  high when the last converted value exceeded 10^DIGITS-1.

## Operation
- States: IDLE and SHIFT.
- Internal registers:
  - shift register, WIDTH bits
  - working BCD accumulator, 4*DIGITS bits
  - bit counter, $clog2(WIDTH+1) bits
  - sticky overflow flag
- IDLE, START=1 at an edge:
  - load BIN_IN into the shift register; clear the accumulator and overflow flag
  - set counter to WIDTH, BUSY to 1, and go to SHIFT.
- IDLE, START=0: nothing changes.
- SHIFT, each edge:
  - Every accumulator digit ≥5 gets +3 (4-bit result, no carry between digits).
  - Shift {accumulator, shift register} left by one. The shift-register MSB enters accumulator bit 0.
  - The bit shifted out of the accumulator's top bit is ORed into the overflow flag.
  - The counter decrements.
- SHIFT edge where the counter goes 1→0:
  - BCD_OUT takes the post-shift accumulator; OVERFLOW takes the final flag.
  - DONE=1 and BUSY=0 for the following cycle; return to IDLE.
- Arithmetic: when no overflow occurs, BCD_OUT equals BIN_IN in decimal. On overflow, BCD_OUT = BIN_IN mod 10^DIGITS and OVERFLOW=1.
- START while BUSY is ignored; BIN_IN changes after capture have no effect.
- BCD_OUT and OVERFLOW hold their values between DONE pulses and are not disturbed while a new conversion runs.
- RESET_N low at any time, including mid-conversion, aborts the conversion: state IDLE and all outputs/registers cleared. No DONE is produced for the aborted request.

## Timing
- Reset values: BUSY=0, DONE=0, BCD_OUT=0, OVERFLOW=0, state IDLE.
- Reset is asynchronous on assertion. Release is sampled at CLK like any input, so the first START is accepted on the first edge with RESET_N high.
- Latency: START accepted at edge k. BUSY is high after edges k..k+WIDTH-1. DONE is high for exactly one cycle after edge k+WIDTH, with results valid in the same cycle.
- Throughput: START held high or reasserted while DONE=1 is accepted on that edge, since the state is IDLE. A new conversion can therefore begin every WIDTH+1 cycles.
- DONE never coincides with BUSY=1.
- WIDTH=1: exactly one SHIFT cycle; DONE follows one edge after accept.

## Test plan
- Defaults, BIN_IN=12345, START one cycle: BUSY for 16 cycles, then DONE one cycle, BCD_OUT=0x12345, OVERFLOW=0.
- Defaults, boundary values:
  - 0 → 0x00000
  - 9999 → 0x09999
  - 10000 → 0x10000
  - 59999 → 0x59999
  - 60000 → 0x60000
  - 65535 → 0x65535
  - OVERFLOW=0 in every case.
- WIDTH=16, DIGITS=4:
  - 10000 → BCD_OUT=0x0000, OVERFLOW=1
  - 9999 → 0x9999, OVERFLOW=0
  - 65535 → 0x5535, OVERFLOW=1
- START held high with BIN_IN=1 then 2: DONE pulses 17 cycles apart with results 0x00001 then 0x00002. START pulses during BUSY produce no extra DONE, and BIN_IN changes during BUSY do not alter the result.
- RESET_N low 5 cycles after accepting 65535: all outputs 0 immediately (asynchronous), no DONE follows. A START after release with 42 gives 0x00042 after 16 cycles.
- Randomised sweep for WIDTH ∈ {1, 8, 16, 32} and DIGITS ∈ {1, 3, 5, 10}: BCD_OUT and OVERFLOW match a reference model (mod 10^DIGITS, value > 10^DIGITS-1).
